// File: rtl/lcd_nibble_driver_pkg.sv
// Shared types and 50 MHz timing constants for the 4-bit HD44780 LCD driver.
package lcd_nibble_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_GAP,
    ST_INIT_WAIT
  } state_t;

  localparam int unsigned DLY_15MS  = 750000;
  localparam int unsigned DLY_4MS1  = 205000;
  localparam int unsigned DLY_100US = 5000;
  localparam int unsigned DLY_40US  = 2000;
  localparam int unsigned DLY_1MS64 = 82000;

  localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  // A zero-length phase still occupies one clock.
  function automatic int unsigned at_least_one(input int unsigned p);
    return (p == 0) ? 1 : p;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter: counts a loaded value down to 1 and flags done there.
module lcd_delay_counter #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count > 1) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count <= 1);

endmodule

// File: rtl/lcd_nibble_driver.sv
// HD44780 4-bit bus driver: one nibble per handshake with setup/E-pulse/hold/exec-wait timing.
// Define LCD_POWERON_INIT_EN to run the panel power-on init sequence after reset.
module lcd_nibble_driver
  import lcd_nibble_driver_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES    = 2,
  parameter int unsigned PULSE_CYCLES    = 12,
  parameter int unsigned HOLD_CYCLES     = 1,
  parameter int unsigned GAP_CYCLES      = DLY_40US,
  parameter int unsigned LONG_GAP_CYCLES = DLY_1MS64,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  input  logic [3:0] iNibble,
  input  logic       iRegisterSelect,
  input  logic       iLongWait,
  output logic       oReady,
  output logic       oBusy,
  output logic [3:0] oLCD,
  output logic       oEnable,
  output logic       oRegisterSelect,
  output logic       oReadWrite
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(at_least_one(SETUP_CYCLES));
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(at_least_one(PULSE_CYCLES));
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(at_least_one(HOLD_CYCLES));
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(at_least_one(GAP_CYCLES));
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(at_least_one(LONG_GAP_CYCLES));

  state_t           state;
  logic             long_q;
  logic             accept;
  logic             cnt_load;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_value;
  logic [CNT_W-1:0] gap_value;

`ifdef LCD_POWERON_INIT_EN
  // The arming cycle is counted as the first cycle of the power-on wait.
  localparam logic [CNT_W-1:0] LD_POWERON = CNT_W'(DLY_15MS - 1);
  logic       init_active;
  logic       init_armed;
  logic [1:0] init_step;
`endif

  assign accept = iValid && oReady;

  always_comb begin
    gap_value = long_q ? LD_LONG : LD_GAP;
`ifdef LCD_POWERON_INIT_EN
    if (init_active) begin
      case (init_step)
        2'd0:    gap_value = CNT_W'(DLY_4MS1);
        2'd1:    gap_value = CNT_W'(DLY_100US);
        default: gap_value = LD_GAP;
      endcase
    end
`endif
  end

  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = LD_SETUP;
    case (state)
      ST_IDLE:  cnt_load = accept;
      ST_SETUP: begin cnt_load = cnt_done; cnt_value = LD_PULSE;  end
      ST_PULSE: begin cnt_load = cnt_done; cnt_value = LD_HOLD;   end
      ST_HOLD:  begin cnt_load = cnt_done; cnt_value = gap_value; end
`ifdef LCD_POWERON_INIT_EN
      ST_GAP:   cnt_load = cnt_done && init_active && (init_step != 2'd3);
      ST_INIT_WAIT: begin
        cnt_load  = !init_armed || cnt_done;
        cnt_value = init_armed ? LD_SETUP : LD_POWERON;
      end
`endif
      default: ;
    endcase
  end

  lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
    .clk   (Clock),
    .rst   (Reset),
    .load  (cnt_load),
    .value (cnt_value),
    .done  (cnt_done)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
`ifdef LCD_POWERON_INIT_EN
      state       <= ST_INIT_WAIT;
      init_active <= 1'b1;
      init_armed  <= 1'b0;
      init_step   <= '0;
`else
      state       <= ST_IDLE;
`endif
      long_q          <= 1'b0;
      oReady          <= 1'b0;
      oBusy           <= 1'b0;
      oLCD            <= '0;
      oEnable         <= 1'b0;
      oRegisterSelect <= 1'b0;
      oReadWrite      <= 1'b0;
    end else begin
      oReadWrite <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state           <= ST_SETUP;
            oLCD            <= iNibble;
            oRegisterSelect <= iRegisterSelect;
            long_q          <= iLongWait;
            oReady          <= 1'b0;
            oBusy           <= 1'b1;
          end else begin
            oReady <= 1'b1;
            oBusy  <= 1'b0;
          end
        end
        ST_SETUP: if (cnt_done) begin state <= ST_PULSE; oEnable <= 1'b1; end
        ST_PULSE: if (cnt_done) begin state <= ST_HOLD;  oEnable <= 1'b0; end
        ST_HOLD:  if (cnt_done) state <= ST_GAP;
        ST_GAP: begin
          if (cnt_done) begin
`ifdef LCD_POWERON_INIT_EN
            if (init_active && init_step != 2'd3) begin
              state           <= ST_SETUP;
              init_step       <= init_step + 2'd1;
              oLCD            <= (init_step == 2'd2) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
              oRegisterSelect <= 1'b0;
            end else begin
              init_active <= 1'b0;
              state       <= ST_IDLE;
              oReady      <= 1'b1;
              oBusy       <= 1'b0;
            end
`else
            state  <= ST_IDLE;
            oReady <= 1'b1;
            oBusy  <= 1'b0;
`endif
          end
        end
`ifdef LCD_POWERON_INIT_EN
        ST_INIT_WAIT: begin
          oBusy <= 1'b1;
          if (!init_armed) begin
            init_armed <= 1'b1;
          end else if (cnt_done) begin
            state           <= ST_SETUP;
            oLCD            <= INIT_NIB_8BIT;
            oRegisterSelect <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Directed self-checking bench for lcd_nibble_driver (default build, power-on init disabled).
module tb_lcd_nibble_driver;

  localparam int unsigned S = 2;
  localparam int unsigned P = 12;
  localparam int unsigned H = 1;
  localparam int unsigned G = 2000;
  localparam int unsigned LG = 82000;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iValid = 1'b0;
  logic [3:0] iNibble = '0;
  logic       iRegisterSelect = 1'b0;
  logic       iLongWait = 1'b0;
  logic       oReady, oBusy, oEnable, oRegisterSelect, oReadWrite;
  logic [3:0] oLCD;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned e_pulses = 0;

  lcd_nibble_driver #(
    .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H),
    .GAP_CYCLES(G), .LONG_GAP_CYCLES(LG), .CNT_W(20)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .iNibble(iNibble),
    .iRegisterSelect(iRegisterSelect), .iLongWait(iLongWait),
    .oReady(oReady), .oBusy(oBusy), .oLCD(oLCD), .oEnable(oEnable),
    .oRegisterSelect(oRegisterSelect), .oReadWrite(oReadWrite)
  );

  always #5 Clock = ~Clock;

  always @(posedge oEnable) e_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after the accept edge; returns on the negedge where oReady is seen high.
  task automatic measure(input logic [3:0] nib, input logic rs, input int unsigned gap, input string tag);
    int unsigned cyc = 0, e_first = 0, e_len = 0, ready_at = 0;
    while (ready_at == 0 && cyc < S + P + H + gap + 100) begin
      @(negedge Clock);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_setup_lcd"}, oLCD, nib);
        check({tag, "_setup_rs"}, oRegisterSelect, rs);
        check({tag, "_busy"}, {oBusy, oReady, oReadWrite}, 3'b100);
      end
      if (cyc == S + P + H) check({tag, "_hold"}, {oEnable, oLCD, oRegisterSelect}, {1'b0, nib, rs});
      if (oEnable) begin
        if (e_first == 0) e_first = cyc;
        e_len++;
      end
      if (oReady) ready_at = cyc;
    end
    check({tag, "_e_start"}, e_first, S + 1);
    check({tag, "_e_len"}, e_len, P);
    check({tag, "_ready_at"}, ready_at, S + P + H + gap + 1);
  endtask

  task automatic send(input logic [3:0] nib, input logic rs, input logic lng);
    int unsigned n = 0;
    while (!oReady && n < 100) begin @(negedge Clock); n++; end
    check("ready_before_send", oReady, 1'b1);
    iNibble = nib; iRegisterSelect = rs; iLongWait = lng; iValid = 1'b1;
    @(posedge Clock);
    #1 iValid = 1'b0; iNibble = 4'hF; iRegisterSelect = ~rs; iLongWait = 1'b0;
  endtask

  initial begin
    int unsigned p0;
    repeat (3) @(negedge Clock);
    check("rst_outputs", {oReady, oBusy, oLCD, oEnable, oRegisterSelect, oReadWrite}, '0);
    Reset = 1'b0;
    @(negedge Clock);
    check("rst_release_ready", {oReady, oBusy}, 2'b10);

    send(4'hA, 1'b1, 1'b0);
    measure(4'hA, 1'b1, G, "single");

    send(4'h0, 1'b0, 1'b1);
    measure(4'h0, 1'b0, LG, "long");

    // Back-to-back with iValid held: second nibble must land on the edge after oReady rises.
    p0 = e_pulses;
    iNibble = 4'h4; iRegisterSelect = 1'b0; iLongWait = 1'b0; iValid = 1'b1;
    @(posedge Clock);
    #1 iNibble = 4'h8;
    measure(4'h4, 1'b0, G, "b2b_a");
    @(posedge Clock);
    #1 iValid = 1'b0;
    measure(4'h8, 1'b0, G, "b2b_b");
    check("b2b_pulses", e_pulses - p0, 2);
    repeat (5) @(negedge Clock);
    check("b2b_no_dup", {oReady, e_pulses - p0}, {1'b1, 32'd2});

    // Reset in the middle of the E pulse.
    send(4'h5, 1'b1, 1'b0);
    repeat (8) @(negedge Clock);
    check("mid_pulse_e", oEnable, 1'b1);
    #2 Reset = 1'b1;
    #1 check("rst_async_e", {oEnable, oLCD, oReady, oBusy}, '0);
    p0 = e_pulses;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("rst_mid_ready", {oReady, oBusy, oLCD, oRegisterSelect}, {2'b10, 4'h0, 1'b0});
    repeat (40) @(negedge Clock);
    check("rst_no_resend", {oEnable, e_pulses - p0}, {1'b0, 32'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
